// File: rtl/adder_pkg.sv
// Purpose: shared types and constants for the adder result path and its accumulator.
// Contents: adder result width, default batch parameters, accumulator FSM state type.
// Ports: none (package).
package adder_pkg;

  // Adder result width: bits 0..3 are r0..r3, bit 4 is the carry-out r4.
  localparam int ADD_RES_W = 5;

  // Default batch size and accumulator width.
  localparam int DEF_COUNT = 4;
  localparam int DEF_ACC_W = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/sum_accumulator_batch_counter.sv
// Purpose: counts accepted items within a batch and flags the final item of the batch.
// Latency: last is combinational from the registered count; clr takes effect next cycle.
// Ports: clk/rst_n clock and async active-low reset; inc counts one accept; clr zeroes the
//        count and wins over inc; last is high while the count equals COUNT-1.
module batch_counter #(
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic last
);

  // Wide enough to hold COUNT itself, which is the count while the batch is held.
  localparam int CW = $clog2(COUNT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign last = (r_cnt == CW'(COUNT - 1));

endmodule

// File: rtl/sum_accumulator.sv
// Purpose: sums COUNT adder results into an ACC_W-bit total and presents each batch total
//          on a valid/ready port; out_valid rises the cycle after the COUNT-th accept.
// Backpressure: in_ready drops while a finished batch waits for out_ready; clear aborts.
// Ports: clk, rst_n, clear; in_valid/in_ready/sum_in input stream;
//        out_valid/out_ready/out_total/out_overflow batch result.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int COUNT = DEF_COUNT,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADD_RES_W-1:0] sum_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_total,
  output logic                 out_overflow
);

  state_t           r_state;
  logic             r_en;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] r_total;
  logic             r_out_ovf;

  logic [ACC_W:0]   w_sum;
  logic             w_ovf_next;
  logic             w_accept;
  logic             w_done;
  logic             w_last;

  // One extra bit captures the carry out of the accumulator's top bit.
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - ADD_RES_W){1'b0}}, sum_in};
  assign w_ovf_next = r_ovf | w_sum[ACC_W];

  // r_en keeps in_ready low until the first clock edge after reset release.
  assign in_ready  = r_en && (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_done    = (r_state == HOLD) && out_ready;

  assign out_total    = r_total;
  assign out_overflow = r_out_ovf;

  batch_counter #(
    .COUNT (COUNT)
  ) u_batch_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_accept),
    .clr   (clear || w_done),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_en      <= 1'b0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_total   <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (clear) begin
        // Abort wins over any same-cycle accept or output handshake.
        r_state <= ACCUM;
        r_acc   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          ACCUM: begin
            if (w_accept) begin
              r_acc <= w_sum[ACC_W-1:0];
              r_ovf <= w_ovf_next;
              if (w_last) begin
                r_total   <= w_sum[ACC_W-1:0];
                r_out_ovf <= w_ovf_next;
                r_state   <= HOLD;
              end
            end
          end
          HOLD: begin
            // Output registers keep their value after the handshake.
            if (out_ready) begin
              r_acc   <= '0;
              r_ovf   <= 1'b0;
              r_state <= ACCUM;
            end
          end
          default: r_state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Purpose: directed self-checking bench for sum_accumulator with COUNT=4, 16 and 1.
// Ports: none; drives three instances sharing clk/rst_n.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that point too.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Instance a: defaults (COUNT=4, ACC_W=8)
  logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [4:0] a_sum;
  logic [7:0] a_total;
  // Instance b: COUNT=16
  logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [4:0] b_sum;
  logic [7:0] b_total;
  // Instance c: COUNT=1
  logic       c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
  logic [4:0] c_sum;
  logic [7:0] c_total;

  sum_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sum_in(a_sum), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_total(a_total),
    .out_overflow(a_ovf)
  );

  sum_accumulator #(.COUNT(16), .ACC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sum_in(b_sum), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_total(b_total),
    .out_overflow(b_ovf)
  );

  sum_accumulator #(.COUNT(1), .ACC_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sum_in(c_sum), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_total(c_total),
    .out_overflow(c_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one item for exactly one edge; sum_in goes X afterwards.
  task automatic feed_a(input logic [4:0] v);
    a_in_valid = 1'b1; a_sum = v; step(); a_in_valid = 1'b0; a_sum = 'x;
  endtask
  task automatic feed_b(input logic [4:0] v);
    b_in_valid = 1'b1; b_sum = v; step(); b_in_valid = 1'b0; b_sum = 'x;
  endtask
  task automatic feed_c(input logic [4:0] v);
    c_in_valid = 1'b1; c_sum = v; step(); c_in_valid = 1'b0; c_sum = 'x;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    n_tests++; if (a_total !== 8'd0) begin n_fail++; $display("FAIL rst_total: got %0d want 0", a_total); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", a_ovf); end
    #20 rst_n = 1'b1;   // released between edges
    #1;
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rel_in_ready: got %b want 0", a_in_ready); end
    step();
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_edge_in_ready: got %b want 1", a_in_ready); end
    n_tests++; if ({b_in_ready, c_in_ready} !== 2'b11) begin n_fail++; $display("FAIL rst_edge_in_ready_bc: got %b want 11", {b_in_ready, c_in_ready}); end
  endtask

  task automatic test_basic();
    a_out_ready = 1'b1;
    feed_a(5'd4); feed_a(5'd4); feed_a(5'd3);
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", a_out_valid); end
    feed_a(5'd17);
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", a_out_valid); end
    n_tests++; if (a_total !== 8'd28) begin n_fail++; $display("FAIL basic_total: got %0d want 28", a_total); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", a_ovf); end
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready: got %b want 0", a_in_ready); end
    step();
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_back: got %b want 1", a_in_ready); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    feed_a(5'd4); feed_a(5'd4); feed_a(5'd3); feed_a(5'd17);
    a_in_valid = 1'b1; a_sum = 5'd9;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (a_out_valid !== 1'b1 || a_total !== 8'd28 || a_in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b total=%0d in_ready=%b want 1/28/0", i, a_out_valid, a_total, a_in_ready);
      end
      step();
    end
    a_in_valid = 1'b0; a_sum = 'x;
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", a_out_valid); end
    feed_a(5'd1); feed_a(5'd2); feed_a(5'd3); feed_a(5'd4);
    n_tests++; if (a_out_valid !== 1'b1 || a_total !== 8'd10) begin n_fail++; $display("FAIL bp_next_batch: got valid=%b total=%0d want 1/10", a_out_valid, a_total); end
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    feed_a(5'd5); step(); step(); step();
    feed_a(5'd6); step();
    feed_a(5'd7);
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid: got %b want 0", a_out_valid); end
    feed_a(5'd8);
    n_tests++; if (a_out_valid !== 1'b1 || a_total !== 8'd26) begin n_fail++; $display("FAIL gap_total: got valid=%b total=%0d want 1/26", a_out_valid, a_total); end
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;
  endtask

  task automatic test_clear();
    feed_a(5'd10); feed_a(5'd11);
    a_clear = 1'b1; step(); a_clear = 1'b0;
    n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_state: got valid=%b in_ready=%b want 0/1", a_out_valid, a_in_ready); end
    feed_a(5'd1); feed_a(5'd2); feed_a(5'd3); feed_a(5'd4);
    n_tests++; if (a_out_valid !== 1'b1 || a_total !== 8'd10) begin n_fail++; $display("FAIL clr_batch: got valid=%b total=%0d want 1/10", a_out_valid, a_total); end
    a_clear = 1'b1; a_out_ready = 1'b1; step(); a_clear = 1'b0; a_out_ready = 1'b0;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_handshake: got %b want 0", a_out_valid); end
    step();
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_no_dup: got %b want 0", a_out_valid); end
    // clear in the same cycle as an accept discards that item
    a_clear = 1'b1; a_in_valid = 1'b1; a_sum = 5'd20; step(); a_clear = 1'b0; a_in_valid = 1'b0; a_sum = 'x;
    feed_a(5'd1); feed_a(5'd1); feed_a(5'd1); feed_a(5'd2);
    n_tests++; if (a_out_valid !== 1'b1 || a_total !== 8'd5) begin n_fail++; $display("FAIL clr_accept: got valid=%b total=%0d want 1/5", a_out_valid, a_total); end
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) feed_b(5'd31);
    n_tests++; if (b_out_valid !== 1'b1 || b_total !== 8'd240 || b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_496: got valid=%b total=%0d ovf=%b want 1/240/1", b_out_valid, b_total, b_ovf); end
    b_out_ready = 1'b1; step(); b_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) feed_b(5'd1);
    n_tests++; if (b_total !== 8'd16 || b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got total=%0d ovf=%b want 16/0", b_total, b_ovf); end
    b_out_ready = 1'b1; step(); b_out_ready = 1'b0;
    // 31*8 + 7 = 255: largest sum without overflow
    for (int i = 0; i < 8; i++) feed_b(5'd31);
    feed_b(5'd7);
    for (int i = 0; i < 7; i++) feed_b(5'd0);
    n_tests++; if (b_total !== 8'd255 || b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_255: got total=%0d ovf=%b want 255/0", b_total, b_ovf); end
    b_out_ready = 1'b1; step(); b_out_ready = 1'b0;
    // 31*8 + 8 = 256: wraps to 0 with overflow
    for (int i = 0; i < 8; i++) feed_b(5'd31);
    feed_b(5'd8);
    for (int i = 0; i < 7; i++) feed_b(5'd0);
    n_tests++; if (b_total !== 8'd0 || b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_256: got total=%0d ovf=%b want 0/1", b_total, b_ovf); end
    b_out_ready = 1'b1; step(); b_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    c_out_ready = 1'b0;
    feed_c(5'd17);
    n_tests++; if (c_out_valid !== 1'b1 || c_total !== 8'd17) begin n_fail++; $display("FAIL c1_first: got valid=%b total=%0d want 1/17", c_out_valid, c_total); end
    c_in_valid = 1'b1; c_sum = 5'd3; step(); c_in_valid = 1'b0; c_sum = 'x;
    n_tests++; if (c_out_valid !== 1'b1 || c_total !== 8'd17) begin n_fail++; $display("FAIL c1_hold: got valid=%b total=%0d want 1/17", c_out_valid, c_total); end
    c_out_ready = 1'b1; step(); c_out_ready = 1'b0;
    n_tests++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL c1_drop: got %b want 0", c_out_valid); end
    feed_c(5'd31);
    n_tests++; if (c_out_valid !== 1'b1 || c_total !== 8'd31 || c_ovf !== 1'b0) begin n_fail++; $display("FAIL c1_second: got valid=%b total=%0d ovf=%b want 1/31/0", c_out_valid, c_total, c_ovf); end
    c_out_ready = 1'b1; step(); c_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    feed_a(5'd1); feed_a(5'd2);
    rst_n = 1'b0; #1;
    n_tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_total !== 8'd0) begin n_fail++; $display("FAIL rstmid_batch: got in_ready=%b valid=%b total=%0d want 0/0/0", a_in_ready, a_out_valid, a_total); end
    #2 rst_n = 1'b1;
    step();
    feed_a(5'd1); feed_a(5'd1); feed_a(5'd1); feed_a(5'd1);
    n_tests++; if (a_out_valid !== 1'b1 || a_total !== 8'd4) begin n_fail++; $display("FAIL rstmid_fresh: got valid=%b total=%0d want 1/4", a_out_valid, a_total); end
    rst_n = 1'b0; #1;
    n_tests++; if (a_out_valid !== 1'b0 || a_total !== 8'd0 || a_ovf !== 1'b0 || a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hold: got valid=%b total=%0d ovf=%b in_ready=%b want 0/0/0/0", a_out_valid, a_total, a_ovf, a_in_ready);
    end
    #2 rst_n = 1'b1;
    step();
    feed_a(5'd1); feed_a(5'd1); feed_a(5'd1); feed_a(5'd1);
    n_tests++; if (a_out_valid !== 1'b1 || a_total !== 8'd4) begin n_fail++; $display("FAIL rstmid_fresh2: got valid=%b total=%0d want 1/4", a_out_valid, a_total); end
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_sum = 'x;
    b_clear = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_sum = 'x;
    c_clear = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_sum = 'x;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_clear();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
